// File: rtl/pe_group_acc_pkg.sv
// pe_group_acc_pkg: shared defaults and saturation bounds for the grouped PE accumulator.
//   TAPS_DEF / NFILT_DEF / DATA_W_DEF / ACC_W_DEF : default geometry
//   sat_max(w) / sat_min(w) : largest / smallest value of a w-bit signed number
package pe_group_acc_pkg;

    localparam int TAPS_DEF   = 5;
    localparam int NFILT_DEF  = 2;
    localparam int DATA_W_DEF = 8;
    localparam int ACC_W_DEF  = 24;

    function automatic logic signed [63:0] sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/pe_group_acc_if.sv
// pe_group_acc_if: weight-load, sample and result signals of pe_group_acc.
//   master : drives weights, ifmap samples and group controls, observes results
//   slave  : the accumulator block itself
interface pe_group_acc_if
    import pe_group_acc_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int NFILT  = NFILT_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
);
    logic                      weight_en;
    logic [DATA_W-1:0]         weight_in;
    logic                      weight_ready;
    logic [TAPS*DATA_W-1:0]    ifmap_in;
    logic                      in_valid;
    logic [3:0]                acc_len;
    logic                      relu_en;
    logic [NFILT*ACC_W-1:0]    sum_out;
    logic                      out_valid;
    logic                      busy;

    modport master (
        output weight_en, weight_in, ifmap_in, in_valid, acc_len, relu_en,
        input  weight_ready, sum_out, out_valid, busy
    );

    modport slave (
        input  weight_en, weight_in, ifmap_in, in_valid, acc_len, relu_en,
        output weight_ready, sum_out, out_valid, busy
    );
endinterface

// File: rtl/pe_tap_tree.sv
// pe_tap_tree: one filter's dot product, two register stages.
//   i_en1    : load stage-1 products (accepted sample)
//   i_en2    : load stage-2 tree sum (stage-1 valid)
//   i_weight : TAPS signed weights, tap 0 in LSBs
//   i_ifmap  : TAPS signed ifmap values, tap 0 in LSBs
//   o_sum    : registered full-width signed sum of the products
module pe_tap_tree
    import pe_group_acc_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int SUM_W  = 2 * DATA_W + $clog2(TAPS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en1,
    input  logic                          i_en2,
    input  logic [TAPS-1:0][DATA_W-1:0]   i_weight,
    input  logic [TAPS-1:0][DATA_W-1:0]   i_ifmap,
    output logic signed [SUM_W-1:0]       o_sum
);
    localparam int PROD_W = 2 * DATA_W;

    logic [TAPS-1:0][PROD_W-1:0] r_prod;
    logic signed [SUM_W-1:0]     r_sum;
    logic signed [SUM_W-1:0]     w_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prod <= '0;
        end else if (i_en1) begin
            for (int k = 0; k < TAPS; k++)
                r_prod[k] <= PROD_W'($signed(i_weight[k])) * PROD_W'($signed(i_ifmap[k]));
        end
    end

    // SUM_W carries log2(TAPS) guard bits, so the sum cannot overflow.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < TAPS; k++)
            w_sum = w_sum + SUM_W'($signed(r_prod[k]));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_sum <= '0;
        else if (i_en2) r_sum <= w_sum;
    end

    assign o_sum = r_sum;
endmodule

// File: rtl/pe_group_acc.sv
// pe_group_acc: NFILT filters sharing one ifmap vector; each sample is a TAPS-wide
// dot product per filter, accumulated with saturation over acc_len samples.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : weight load (weight_en/weight_in/weight_ready), samples
//              (ifmap_in/in_valid/acc_len/relu_en), results (sum_out/out_valid/busy)
// Latency: sample accepted in cycle t, its group result pulses out_valid at t+3.
module pe_group_acc
    import pe_group_acc_pkg::*;
#(
    parameter int TAPS   = TAPS_DEF,
    parameter int NFILT  = NFILT_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic           clk,
    input  logic           rst,
    pe_group_acc_if.slave  bus
);
    localparam int NW    = NFILT * TAPS;
    localparam int IDX_W = (NW > 1) ? $clog2(NW) : 1;
    localparam int SUM_W = 2 * DATA_W + $clog2(TAPS);

    logic [NW-1:0][DATA_W-1:0]     r_bank;
    logic [IDX_W-1:0]              r_idx;
    logic                          r_wready;
    logic [3:0]                    r_cnt, r_len;
    logic                          r_relu;
    logic [1:0]                    r_vld_pipe, r_last_pipe, r_relu_pipe;
    logic                          r_out_vld;
    logic                          w_busy, w_wr, w_acc, w_last, w_relu;
    logic [3:0]                    w_len;
    logic [NFILT-1:0][ACC_W-1:0]   w_sum_out;

    assign w_busy = (|r_vld_pipe) || (r_cnt != 4'd0);
    assign w_wr   = bus.weight_en && !w_busy;
    assign w_acc  = bus.in_valid && r_wready && !bus.weight_en;

    // Weight bank: filter-major, tap-minor; ready only once the full bank is written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bank   <= '0;
            r_idx    <= '0;
            r_wready <= 1'b0;
        end else if (w_wr) begin
            r_bank[r_idx] <= bus.weight_in;
            if (r_idx == IDX_W'(NW - 1)) begin
                r_idx    <= '0;
                r_wready <= 1'b1;
            end else begin
                r_idx    <= r_idx + IDX_W'(1);
                r_wready <= 1'b0;
            end
        end
    end

    // Group length and ReLU come from the live inputs on a group's first sample,
    // from the latched copies afterwards.
    always_comb begin
        w_len  = r_len;
        w_relu = r_relu;
        if (r_cnt == 4'd0) begin
            w_len  = (bus.acc_len == 4'd0) ? 4'd1 : bus.acc_len;
            w_relu = bus.relu_en;
        end
        w_last = (r_cnt + 4'd1 == w_len);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_len  <= '0;
            r_relu <= 1'b0;
        end else if (w_acc) begin
            if (r_cnt == 4'd0) begin
                r_len  <= w_len;
                r_relu <= w_relu;
            end
            r_cnt <= w_last ? 4'd0 : r_cnt + 4'd1;
        end
    end

    // last/relu tags travel with the valid bit to the accumulate stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe  <= '0;
            r_last_pipe <= '0;
            r_relu_pipe <= '0;
            r_out_vld   <= 1'b0;
        end else begin
            r_vld_pipe  <= {r_vld_pipe[0], w_acc};
            r_last_pipe <= {r_last_pipe[0], w_last};
            r_relu_pipe <= {r_relu_pipe[0], w_relu};
            r_out_vld   <= r_vld_pipe[1] && r_last_pipe[1];
        end
    end

    for (genvar f = 0; f < NFILT; f++) begin : g_filt
        logic signed [SUM_W-1:0] w_tree;
        logic signed [63:0]      w_ext;
        logic signed [ACC_W-1:0] w_sat;
        logic signed [ACC_W-1:0] r_acc, r_sum;

        pe_tap_tree #(
            .TAPS   (TAPS),
            .DATA_W (DATA_W),
            .SUM_W  (SUM_W)
        ) u_tree (
            .clk      (clk),
            .rst      (rst),
            .i_en1    (w_acc),
            .i_en2    (r_vld_pipe[0]),
            .i_weight (r_bank[f*TAPS +: TAPS]),
            .i_ifmap  (bus.ifmap_in),
            .o_sum    (w_tree)
        );

        always_comb begin
            w_ext = 64'(r_acc) + 64'(w_tree);
            if (w_ext > sat_max(ACC_W))      w_sat = ACC_W'(sat_max(ACC_W));
            else if (w_ext < sat_min(ACC_W)) w_sat = ACC_W'(sat_min(ACC_W));
            else                             w_sat = w_ext[ACC_W-1:0];
        end

        // The group's last sample publishes and clears in the same edge, so the
        // next group's first sample (one cycle behind) starts from zero.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_acc <= '0;
                r_sum <= '0;
            end else if (r_vld_pipe[1]) begin
                if (r_last_pipe[1]) begin
                    r_acc <= '0;
                    r_sum <= (r_relu_pipe[1] && w_sat < 0) ? '0 : w_sat;
                end else begin
                    r_acc <= w_sat;
                end
            end
        end

        assign w_sum_out[f] = r_sum;
    end

    assign bus.weight_ready = r_wready;
    assign bus.sum_out      = w_sum_out;
    assign bus.out_valid    = r_out_vld;
    assign bus.busy         = w_busy;
endmodule

// File: tb/tb_pe_group_acc.sv
// tb_pe_group_acc: directed vectors with hand-computed results for pe_group_acc
// (TAPS=5, NFILT=2, DATA_W=8, ACC_W=16).
module tb_pe_group_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    pe_group_acc_if #(.TAPS(5), .NFILT(2), .DATA_W(8), .ACC_W(16)) bus ();

    pe_group_acc #(.TAPS(5), .NFILT(2), .DATA_W(8), .ACC_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_w(input logic [9:0][7:0] w);
        for (int i = 0; i < 10; i++) begin
            bus.weight_en = 1'b1;
            bus.weight_in = w[i];
            tick();
            if (i == 0) chk("wready_clr", bus.weight_ready, 0);
        end
        bus.weight_en = 1'b0;
        chk("wready_set", bus.weight_ready, 1);
    endtask

    // n samples on consecutive edges 1..n; records out_valid pulses over 'total' edges.
    task automatic run(input int n, input logic [39:0] ifm, input logic [3:0] len,
                       input logic relu, input int total, output int pulses,
                       output int first_at, output int last_at,
                       output logic signed [63:0] s0f, output logic signed [63:0] s1f,
                       output logic signed [63:0] s0l, output logic signed [63:0] s1l);
        pulses = 0; first_at = -1; last_at = -1;
        s0f = 0; s1f = 0; s0l = 0; s1l = 0;
        for (int k = 1; k <= total; k++) begin
            bus.in_valid = (k <= n);
            bus.ifmap_in = ifm;
            bus.acc_len  = len;
            bus.relu_en  = relu;
            tick();
            if (bus.out_valid) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = k;
                    s0f = $signed(bus.sum_out[15:0]);
                    s1f = $signed(bus.sum_out[31:16]);
                end
                last_at = k;
                s0l = $signed(bus.sum_out[15:0]);
                s1l = $signed(bus.sum_out[31:16]);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    logic [9:0][7:0]    w;
    int                 p, fa, la;
    logic signed [63:0] a0, a1, b0, b1;

    initial begin
        bus.weight_en = 0; bus.weight_in = 0; bus.ifmap_in = 0;
        bus.in_valid = 0; bus.acc_len = 0; bus.relu_en = 0;
        tick(); tick();
        chk("rst_wready", bus.weight_ready, 0);
        chk("rst_ovld", bus.out_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_sum", bus.sum_out, 0);
        rst = 1'b0;

        // samples before any weight load are dropped
        run(1, {5{8'd2}}, 4'd1, 1'b0, 4, p, fa, la, a0, a1, b0, b1);
        chk("noload_pulses", p, 0);

        // all-ones weights, ifmap 2, single-sample group
        for (int i = 0; i < 10; i++) w[i] = 8'd1;
        load_w(w);
        run(1, {5{8'd2}}, 4'd1, 1'b0, 5, p, fa, la, a0, a1, b0, b1);
        chk("b1_pulses", p, 1);
        chk("b1_lat", fa, 3);
        chk("b1_f0", a0, 10);
        chk("b1_f1", a1, 10);
        chk("b1_busy_end", bus.busy, 0);
        tick(); tick();
        chk("hold_f0", $signed(bus.sum_out[15:0]), 10);
        chk("hold_ovld", bus.out_valid, 0);

        // filter0 1..5, filter1 -1..-5, ifmap 1..5, three-sample group
        for (int k = 0; k < 5; k++) begin
            w[k]     = 8'(k + 1);
            w[5 + k] = 8'(-(k + 1));
        end
        load_w(w);
        run(3, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 4'd3, 1'b0, 8, p, fa, la, a0, a1, b0, b1);
        chk("grp3_pulses", p, 1);
        chk("grp3_lat", fa, 5);
        chk("grp3_f0", a0, 165);
        chk("grp3_f1", a1, -165);
        run(3, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 4'd3, 1'b1, 8, p, fa, la, a0, a1, b0, b1);
        chk("relu_pulses", p, 1);
        chk("relu_f0", a0, 165);
        chk("relu_f1", a1, 0);

        // weight_en while busy is dropped
        bus.in_valid = 1'b1; bus.ifmap_in = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        bus.acc_len = 4'd1; bus.relu_en = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        chk("busy_hi", bus.busy, 1);
        bus.weight_en = 1'b1; bus.weight_in = 8'd50;
        tick();
        bus.weight_en = 1'b0;
        chk("busy_wready", bus.weight_ready, 1);
        tick();
        chk("busy_ovld", bus.out_valid, 1);
        chk("busy_clear", bus.busy, 0);
        run(1, {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 4'd1, 1'b0, 5, p, fa, la, a0, a1, b0, b1);
        chk("wbusy_f0", a0, 55);
        chk("wbusy_f1", a1, -55);

        // back-to-back two-sample groups
        for (int i = 0; i < 10; i++) w[i] = 8'd1;
        load_w(w);
        run(4, {5{8'd1}}, 4'd2, 1'b0, 9, p, fa, la, a0, a1, b0, b1);
        chk("b2b_pulses", p, 2);
        chk("b2b_first", fa, 4);
        chk("b2b_last", la, 6);
        chk("b2b_f0a", a0, 10);
        chk("b2b_f0b", b0, 10);
        chk("b2b_f1b", b1, 10);

        // negative saturation: 5*127*-128 = -81280 per sample
        for (int i = 0; i < 10; i++) w[i] = 8'd127;
        load_w(w);
        run(15, {5{8'h80}}, 4'd15, 1'b0, 20, p, fa, la, a0, a1, b0, b1);
        chk("sat_pulses", p, 1);
        chk("sat_lat", fa, 17);
        chk("sat_f0", a0, -32768);
        chk("sat_f1", a1, -32768);

        // reset mid-group discards everything
        bus.in_valid = 1'b1; bus.ifmap_in = {5{8'd1}}; bus.acc_len = 4'd3;
        tick(); tick();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #2;
        chk("mrst_busy", bus.busy, 0);
        chk("mrst_wready", bus.weight_ready, 0);
        tick();
        rst = 1'b0;
        run(3, {5{8'd1}}, 4'd3, 1'b0, 8, p, fa, la, a0, a1, b0, b1);
        chk("mrst_pulses", p, 0);
        chk("mrst_busy_after", bus.busy, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pe_group_acc.md
PE_GROUP_ACC -- requirements
Module: pe_group_acc

Interface
REQ-001 SHALL have parameter TAPS, default 5, products summed per filter per sample.
REQ-002 SHALL have parameter NFILT, default 2, filters sharing one ifmap vector.
REQ-003 SHALL have parameter DATA_W, default 8, signed weight/ifmap width.
REQ-004 SHALL have parameter ACC_W, default 24, signed accumulator/output width.
REQ-005 SHALL have port clk  in  1  sole clock, rising edge.
REQ-006 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-007 SHALL have port weight_en  in  1  weight load strobe, one weight per cycle.
REQ-008 SHALL have port weight_in  in  DATA_W  signed weight, filter-major then tap order.
REQ-009 SHALL have port weight_ready  out  1  high when all NFILT*TAPS weights loaded.
REQ-010 SHALL have port ifmap_in  in  TAPS*DATA_W  signed ifmap taps, tap 0 in LSBs.
REQ-011 SHALL have port in_valid  in  1  ifmap_in valid this cycle.
REQ-012 SHALL have port acc_len  in  4  samples accumulated per output; 0 treated as 1.
REQ-013 SHALL have port relu_en  in  1  clamp negative results to 0 at output.
REQ-014 SHALL have port sum_out  out  NFILT*ACC_W  per-filter result, filter 0 in LSBs.
REQ-015 SHALL have port out_valid  out  1  one-cycle pulse, sum_out valid.
REQ-016 SHALL have port busy  out  1  any sample in pipeline or partial accumulation held.

Function
REQ-017 Weight load SHALL write weight_in to bank[idx] on weight_en, idx counting 0..NFILT*TAPS-1, then wrap to 0.
REQ-018 weight_ready SHALL rise the cycle after idx wraps; SHALL clear on first weight_en of a new load.
REQ-019 weight_en while busy=1 SHALL be ignored (bank, idx unchanged).
REQ-020 in_valid SHALL be ignored when weight_ready=0 or weight_en=1 in the same cycle.
REQ-021 Stage 1 (cycle t+1): per filter, per tap signed product, 2*DATA_W bits, registered.
REQ-022 Stage 2 (cycle t+2): per filter, signed adder tree of TAPS products, registered, full width (no overflow).
REQ-023 Stage 3 (cycle t+3): accumulator += tree sum, saturating to signed ACC_W range.
REQ-024 Valid SHALL propagate with data through all stages; pipeline SHALL accept one sample per cycle, no stalls.
REQ-025 Sample counter SHALL count accepted samples; acc_len SHALL be latched at first sample of each group.
REQ-026 On the group's last sample: out_valid=1 at t+3, sum_out = final accumulator (ReLU applied if relu_en latched at group start), accumulator cleared for next group same cycle.
REQ-027 Back-to-back groups SHALL have no gap cycle; first sample of next group SHALL start from 0, not the prior sum.
REQ-028 sum_out SHALL hold its value between out_valid pulses.
REQ-029 busy SHALL be high from accepted in_valid until out_valid of the group's last sample.

Reset
REQ-030 rst SHALL asynchronously clear: weight bank, idx, weight_ready, pipeline regs and valids, accumulators, sample counter, sum_out, out_valid, busy to 0.
REQ-031 rst mid-load or mid-group SHALL discard all partial state; no out_valid SHALL follow.

Structure
REQ-032 Shared package SHALL hold default TAPS, NFILT, DATA_W, ACC_W and a saturation-bound function.
REQ-033 One sub-module pe_tap_tree (TAPS products + adder tree, stages 1-2) SHALL be instantiated NFILT times.

Verification
REQ-034 Load weights all 1, ifmap taps all 2, acc_len=1 -> out_valid 3 cycles after in_valid, sum_out each filter = 10.
REQ-035 Filter0 weights 1..5, filter1 -1..-5, ifmap 1..5, acc_len=3, three consecutive samples -> single pulse, sums 165 / -165; with relu_en -> 165 / 0.
REQ-036 Weights 127, ifmap -128, acc_len=15, ACC_W=16 -> filter sums saturate to -32768.
REQ-037 Two back-to-back groups acc_len=2 (weights 1, ifmap 1) -> pulses at t+4 and t+6, each 10.
REQ-038 rst asserted after 2 of 3 samples -> no out_valid; weight_ready=0; in_valid ignored until reload.
REQ-039 weight_en while busy -> bank unchanged, next result identical to prior weights.
